// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg -- opcode constants and FSM state type shared by the hazard
//                    controller and the main Control decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if -- pipeline-to-hazard-controller signal bundle.
//                   master = pipeline side, slave = hazard controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;

  logic [6:0] IFID_Op_i;
  logic [4:0] IFID_Rs1_i;
  logic [4:0] IFID_Rs2_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_Rd_i;
  logic       Branch_taken_i;
  logic       Miss_i;

  logic       NoOp_o;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       Flush_o;
  logic       Stall_o;
  logic       Busy_o;

  modport master (
    output IFID_Op_i, IFID_Rs1_i, IFID_Rs2_i, IDEX_MemRead_i, IDEX_Rd_i,
           Branch_taken_i, Miss_i,
    input  NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Stall_o, Busy_o
  );

  modport slave (
    input  IFID_Op_i, IFID_Rs1_i, IFID_Rs2_i, IDEX_MemRead_i, IDEX_Rd_i,
           Branch_taken_i, Miss_i,
    output NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Stall_o, Busy_o
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_src_use.sv
// ============================================================================
// hazard_src_use -- decodes which source registers an opcode actually reads,
//                   so unused register fields never raise false hazards.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_src_use
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  always_comb begin
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    case (op_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        rs1_used_o = 1'b1;
      end
      default: begin
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl -- pipeline hazard controller: memory-miss stall FSM, load-use
//                bubble insertion and taken-branch flush, in that priority.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating event counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   StallCnt_o,
  output logic [15:0]   BubbleCnt_o,
  output logic [15:0]   FlushCnt_o
`endif
);

  localparam logic [3:0] C_LAT_M1 = 4'(MEM_LAT - 1);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_mem_stall;
  logic w_load_use;
  logic w_bubble;
  logic w_flush_evt;

  logic w_noop, w_pcwrite, w_ifidwrite, w_flush, w_stall, w_busy;

  hazard_src_use u_src_use (
    .op_i       (hz.IFID_Op_i),
    .rs1_used_o (w_rs1_used),
    .rs2_used_o (w_rs2_used)
  );

  // The miss cycle itself stalls from IDLE, so the wait state only covers
  // the remaining MEM_LAT-1 cycles.
  assign w_mem_stall = (state_q == ST_MEM_WAIT) || hz.Miss_i;

  assign w_load_use = hz.IDEX_MemRead_i && (hz.IDEX_Rd_i != 5'd0) &&
                      ((w_rs1_used && (hz.IFID_Rs1_i == hz.IDEX_Rd_i)) ||
                       (w_rs2_used && (hz.IFID_Rs2_i == hz.IDEX_Rd_i)));

  assign w_bubble    = !rst_i && !w_mem_stall && w_load_use;
  assign w_flush_evt = !rst_i && !w_mem_stall && !w_load_use && hz.Branch_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hz.Miss_i) begin
          cnt_d = C_LAT_M1;
          if (C_LAT_M1 != 4'd0) begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        // Further misses are ignored here; the counter never reloads.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_noop      = 1'b0;
    w_pcwrite   = 1'b1;
    w_ifidwrite = 1'b1;
    w_flush     = 1'b0;
    w_stall     = 1'b0;
    w_busy      = 1'b0;
    if (rst_i) begin
      w_noop      = 1'b1;
      w_flush     = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (w_mem_stall) begin
      w_stall     = 1'b1;
      w_busy      = (state_q == ST_MEM_WAIT);
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (w_load_use) begin
      w_noop      = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (hz.Branch_taken_i) begin
      w_flush     = 1'b1;
    end
  end

  assign hz.NoOp_o      = w_noop;
  assign hz.PCWrite_o   = w_pcwrite;
  assign hz.IFIDWrite_o = w_ifidwrite;
  assign hz.Flush_o     = w_flush;
  assign hz.Stall_o     = w_stall;
  assign hz.Busy_o      = w_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Counters saturate rather than wrap so long runs never read as small.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (w_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (w_flush_evt && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  assign StallCnt_o  = stall_cnt_q;
  assign BubbleCnt_o = bubble_cnt_q;
  assign FlushCnt_o  = flush_cnt_q;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_bubble ^ w_flush_evt;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, memory-miss stall length in cycles (legal 1..15).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- IFID_Op_i  in  7  opcode of instruction in ID
- IFID_Rs1_i, IFID_Rs2_i  in  5 each  ID source registers
- IDEX_MemRead_i  in  1  EX instruction is a load
- IDEX_Rd_i  in  5  EX destination register
- Branch_taken_i  in  1  branch resolved taken in ID
- Miss_i  in  1  one-cycle pulse, data-memory miss in MEM
- NoOp_o  out  1  drives Control NoOp input (bubble into ID/EX)
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register enable
- Flush_o  out  1  clear IF/ID (squash fetched instruction)
- Stall_o  out  1  freeze all pipeline registers
- Busy_o  out  1  memory-wait state active

Function
REQ-003 SHALL implement FSM {IDLE, MEM_WAIT} and a 4-bit down-counter.
REQ-004 IDLE -> MEM_WAIT on Miss_i=1; counter loads MEM_LAT-1.
REQ-005 MEM_WAIT: counter decrements each cycle; at counter=0, next state IDLE; total Stall_o high for exactly MEM_LAT cycles, starting in the Miss_i cycle.
REQ-006 Miss_i asserted while in MEM_WAIT SHALL be ignored (no counter reload).
REQ-007 Rs1 used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011; Rs2 used only for 0110011, 0100011, 1100011; opcode 0000000 uses neither.
REQ-008 Load-use hazard = IDEX_MemRead_i & IDEX_Rd_i!=0 & (used Rs1 == IDEX_Rd_i | used Rs2 == IDEX_Rd_i).
REQ-009 Priority: memory stall > load-use > branch flush; lower-priority events in a stalled cycle are suppressed, not queued (sources hold their inputs).
REQ-010 Memory stall cycle: Stall_o=1, Busy_o=1 (in MEM_WAIT), PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0.
REQ-011 Load-use cycle: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0, Stall_o=0; exactly one bubble per hazard.
REQ-012 Branch cycle (no stall, no hazard, Branch_taken_i=1): Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0.
REQ-013 Otherwise: PCWrite_o=1, IFIDWrite_o=1, others 0.
REQ-014 All outputs SHALL be combinational from state/counter and current inputs (zero-cycle latency).
REQ-015 Load-use hazard and taken branch together SHALL produce the load-use response only.

Reset
REQ-016 rst_i=1 SHALL immediately force state IDLE, counter 0, perf counters 0.
REQ-017 During reset: Stall_o=0, Busy_o=0, NoOp_o=1, Flush_o=1, PCWrite_o=0, IFIDWrite_o=0.
REQ-018 Reset asserted mid-MEM_WAIT SHALL abort the wait; after release, behaviour is as from IDLE.

Configuration
REQ-019 Macro HAZARD_PERF_CNT_EN defined: SHALL add outputs StallCnt_o[31:0] (cycles with Stall_o=1), BubbleCnt_o[15:0] (load-use bubbles), FlushCnt_o[15:0] (branch flushes), all saturating at maximum, cleared only by reset.
REQ-020 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-021 Shared package SHALL hold opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_NOP) and the FSM state enum, reused by Control.
REQ-022 One sub-module hazard_src_use (opcode -> rs1_used, rs2_used), purely combinational.

Verification
REQ-023 Load x5 in EX (MemRead=1, Rd=5), ID add with Rs2=5 -> NoOp_o=1, PCWrite_o=0 for one cycle; next cycle all normal.
REQ-024 Same load, ID addi (0010011) with Rs2 field=5, Rs1=6 -> no stall.
REQ-025 IDEX_Rd_i=0 with MemRead, ID Rs1=0 -> no stall.
REQ-026 Miss_i pulse, MEM_LAT=4 -> Stall_o high cycles 0..3, Busy_o high cycles 1..3, second Miss_i at cycle 2 ignored; IDLE at cycle 4.
REQ-027 Branch_taken_i=1 during MEM_WAIT -> Flush_o=0; same branch after wait -> Flush_o=1 one cycle.
REQ-028 rst_i pulsed at cycle 2 of MEM_WAIT -> Stall_o=0 immediately; with HAZARD_PERF_CNT_EN, StallCnt_o reads 0.
